kbd_scan_ctrl: RTL

//  Sequencer and decoder behind the PS/2 bit receiver (bitrec).
//  - Consumes received bytes (dout/dout_new) and strips the E0, F0 and E1 prefixes.
//  - Turns each scancode into one make or break event and buffers events in a small FIFO.
//  - Runs a frame watchdog on kbd_clk. On a stalled frame it pulses a clear to the receiver.
//  - Sits between bitrec and the game-logic key decoders.

---
 rtl/kbd_pkg.sv | 42 ++++
 rtl/kbd_evt_fifo.sv | 53 +++++
 rtl/kbd_scan_ctrl.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/kbd_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : kbd_pkg                                                      |
// | Description : Shared types and byte constants for the PS/2 scan decoder.   |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package kbd_pkg;

  typedef enum logic [2:0] {
    WAIT_ST    = 3'd0,
    EXT_ST     = 3'd1,
    BRK_ST     = 3'd2,
    EXT_BRK_ST = 3'd3,
    SKIP_ST    = 3'd4
  } kbd_st_t;

  localparam logic [7:0] PFX_EXT    = 8'hE0;
  localparam logic [7:0] PFX_BRK    = 8'hF0;
  localparam logic [7:0] PFX_PAUSE  = 8'hE1;
  localparam logic [7:0] FAKE_SHIFT = 8'h12;
  localparam logic [8:0] PAUSE_CODE = 9'h0E1;

  // Keyboard replies and error bytes that never represent a key.
  localparam int         N_CTRL = 6;
  localparam logic [7:0] CTRL_BYTES [N_CTRL] = '{8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF};

  typedef struct packed {
    logic       make;
    logic [8:0] code;
  } kbd_evt_t;

  function automatic logic is_ctrl_byte(input logic [7:0] b);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < N_CTRL; i++) begin
      if (b == CTRL_BYTES[i]) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage
`default_nettype wire

// File: rtl/kbd_evt_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : kbd_evt_fifo                                                 |
// | Description : First-word fall-through FIFO of decoded key events.          |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module kbd_evt_fifo
  import kbd_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     resetN,
  input  logic     push,
  input  kbd_evt_t push_data,
  input  logic     pop,
  output logic     full,
  output logic     empty,
  output kbd_evt_t head
);

  localparam int ADDR_W = (DEPTH > 2) ? $clog2(DEPTH) : 1;

  kbd_evt_t          r_mem [DEPTH];
  logic [ADDR_W:0]   r_wr_ptr;
  logic [ADDR_W:0]   r_rd_ptr;
  logic              w_wr_en;
  logic              w_rd_en;

  // Extra MSB on the pointers distinguishes full from empty.
  assign empty   = (r_wr_ptr == r_rd_ptr);
  assign full    = (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]) &&
                   (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]);
  assign w_rd_en = pop & ~empty;
  assign w_wr_en = push & (~full | w_rd_en);
  assign head    = r_mem[r_rd_ptr[ADDR_W-1:0]];

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_wr_en) begin
        r_mem[r_wr_ptr[ADDR_W-1:0]] <= push_data;
        r_wr_ptr                    <= r_wr_ptr + 1'b1;
      end
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/kbd_scan_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : kbd_scan_ctrl                                                |
// | Description : PS/2 scancode prefix decoder, event FIFO and frame watchdog. |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module kbd_scan_ctrl
  import kbd_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int PAUSE_SKIP     = 7
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic [7:0] din,
  input  logic       din_new,
  input  logic       kbd_clk,
  output logic       rec_clrN,
  output logic       evt_valid,
  output logic [8:0] evt_code,
  output logic       evt_make,
  input  logic       evt_rd,
  output logic       ovf,
  input  logic       ovf_clr
);

  localparam int IDLE_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int SKIP_W = $clog2(PAUSE_SKIP + 1) + 1;

  kbd_st_t           r_state;
  kbd_st_t           w_next_state;
  logic [SKIP_W-1:0] r_skip_cnt;
  logic              w_push;
  kbd_evt_t          w_push_evt;
  logic              w_full;
  logic              w_empty;
  kbd_evt_t          w_head;
  logic              w_drop;
  logic              r_ovf;

  logic              r_kc_s1;
  logic              r_kc_s2;
  logic              r_kc_prev;
  logic              w_fall;
  logic [3:0]        r_fall_cnt;
  logic [IDLE_W-1:0] r_idle_cnt;
  logic              w_timeout;
  logic              r_rec_clr_n;

  // ---------------- watchdog ----------------
  // Synchronizer resets high so the idle PS/2 line never looks like a fall.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_kc_s1   <= 1'b1;
      r_kc_s2   <= 1'b1;
      r_kc_prev <= 1'b1;
    end else begin
      r_kc_s1   <= kbd_clk;
      r_kc_s2   <= r_kc_s1;
      r_kc_prev <= r_kc_s2;
    end
  end

  assign w_fall    = r_kc_prev & ~r_kc_s2;
  assign w_timeout = (r_fall_cnt != 4'd0) && (r_idle_cnt == IDLE_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_fall_cnt  <= '0;
      r_idle_cnt  <= '0;
      r_rec_clr_n <= 1'b1;
    end else begin
      r_rec_clr_n <= ~w_timeout;
      if (w_timeout) begin
        r_fall_cnt <= '0;
        r_idle_cnt <= '0;
      end else begin
        if (din_new)                        r_fall_cnt <= {3'b000, w_fall};
        else if (w_fall && r_fall_cnt != 4'hF) r_fall_cnt <= r_fall_cnt + 4'd1;

        if (w_fall)                 r_idle_cnt <= '0;
        else if (r_fall_cnt != 4'd0) r_idle_cnt <= r_idle_cnt + 1'b1;
      end
    end
  end

  assign rec_clrN = r_rec_clr_n & resetN;

  // ---------------- byte FSM ----------------
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) r_state <= WAIT_ST;
    else         r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    if (w_timeout) begin
      w_next_state = WAIT_ST;
    end else if (din_new) begin
      case (r_state)
        WAIT_ST: begin
          if      (din == PFX_EXT)   w_next_state = EXT_ST;
          else if (din == PFX_BRK)   w_next_state = BRK_ST;
          else if (din == PFX_PAUSE) w_next_state = SKIP_ST;
        end
        EXT_ST: begin
          if      (din == PFX_BRK) w_next_state = EXT_BRK_ST;
          else if (din != PFX_EXT) w_next_state = WAIT_ST;
        end
        BRK_ST:     if (din != PFX_BRK) w_next_state = WAIT_ST;
        EXT_BRK_ST: w_next_state = WAIT_ST;
        SKIP_ST:    if (r_skip_cnt <= SKIP_W'(1)) w_next_state = WAIT_ST;
        default:    w_next_state = WAIT_ST;
      endcase
    end
  end

  always_comb begin
    w_push     = 1'b0;
    w_push_evt = '0;
    if (din_new && !w_timeout) begin
      case (r_state)
        WAIT_ST: begin
          if (din != PFX_EXT && din != PFX_BRK && din != PFX_PAUSE && !is_ctrl_byte(din)) begin
            w_push          = 1'b1;
            w_push_evt.make = 1'b1;
            w_push_evt.code = {1'b0, din};
          end
        end
        EXT_ST: begin
          if (din != PFX_BRK && din != PFX_EXT && din != FAKE_SHIFT) begin
            w_push          = 1'b1;
            w_push_evt.make = 1'b1;
            w_push_evt.code = {1'b1, din};
          end
        end
        BRK_ST: begin
          if (din != PFX_BRK) begin
            w_push          = 1'b1;
            w_push_evt.make = 1'b0;
            w_push_evt.code = {1'b0, din};
          end
        end
        EXT_BRK_ST: begin
          if (din != FAKE_SHIFT) begin
            w_push          = 1'b1;
            w_push_evt.make = 1'b0;
            w_push_evt.code = {1'b1, din};
          end
        end
        SKIP_ST: begin
          if (r_skip_cnt <= SKIP_W'(1)) begin
            w_push          = 1'b1;
            w_push_evt.make = 1'b1;
            w_push_evt.code = PAUSE_CODE;
          end
        end
        default: w_push = 1'b0;
      endcase
    end
  end

  // Pause sequence carries no break codes; its trailing bytes are swallowed.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_skip_cnt <= '0;
    end else if (w_timeout) begin
      r_skip_cnt <= '0;
    end else if (din_new) begin
      if (r_state == WAIT_ST && din == PFX_PAUSE)      r_skip_cnt <= SKIP_W'(PAUSE_SKIP);
      else if (r_state == SKIP_ST && r_skip_cnt != '0) r_skip_cnt <= r_skip_cnt - 1'b1;
    end
  end

  // ---------------- event FIFO ----------------
  kbd_evt_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .resetN    (resetN),
    .push      (w_push),
    .push_data (w_push_evt),
    .pop       (evt_rd),
    .full      (w_full),
    .empty     (w_empty),
    .head      (w_head)
  );

  assign w_drop = w_push & w_full & ~evt_rd;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)      r_ovf <= 1'b0;
    else if (w_drop)  r_ovf <= 1'b1;
    else if (ovf_clr) r_ovf <= 1'b0;
  end

  assign evt_valid = ~w_empty;
  assign evt_code  = w_head.code;
  assign evt_make  = w_head.make;
  assign ovf       = r_ovf;

endmodule
`default_nettype wire
